// File: rtl/pipeline_ctrl.sv
// Hazard and stall sequencer for the 5-stage core: drives PC/pipeline-register
// load and flush controls and arbitrates the unified memory port.
module pipeline_ctrl #(
    parameter int unsigned LONG_LAT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs2,
    input  logic       id_halt,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       ex_branch_taken,
    input  logic       ex_long_op,
    input  logic       mem_access,
    output logic       pc_load,
    output logic       ifid_load,
    output logic       idex_load,
    output logic       exmem_load,
    output logic       memwb_load,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       mem_sel,
    output logic       ex_busy,
    output logic       halted
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LONG = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               lu;
    logic               eval_run;
    logic               long_eff;

    assign lu = ex_mem_read && (ex_rd != 5'd0) &&
                ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

    // State and long-op countdown register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state and combinational controls; everything is forced low in reset
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pc_load     = 1'b0;
        ifid_load   = 1'b0;
        idex_load   = 1'b0;
        exmem_load  = 1'b0;
        memwb_load  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        mem_sel     = 1'b0;
        ex_busy     = 1'b0;
        halted      = 1'b0;
        eval_run    = 1'b0;
        long_eff    = 1'b0;

        if (rst) begin
            case (state)
                RUN: begin
                    eval_run = 1'b1;
                    long_eff = ex_long_op;
                end
                LONG: begin
                    if (cnt != '0) begin
                        exmem_load  = 1'b1;
                        memwb_load  = 1'b1;
                        exmem_flush = 1'b1;
                        ex_busy     = 1'b1;
                        mem_sel     = mem_access;
                        cnt_nxt     = cnt - CNT_W'(1);
                    end else begin
                        // Release cycle: the long op still sits in EX but is masked
                        eval_run = 1'b1;
                    end
                end
                HALT: begin
                    ifid_load  = 1'b1;
                    idex_load  = 1'b1;
                    exmem_load = 1'b1;
                    memwb_load = 1'b1;
                    ifid_flush = 1'b1;
                    halted     = 1'b1;
                    mem_sel    = mem_access;
                end
                default: state_nxt = RUN;
            endcase

            if (eval_run) begin
                pc_load    = 1'b1;
                ifid_load  = 1'b1;
                idex_load  = 1'b1;
                exmem_load = 1'b1;
                memwb_load = 1'b1;
                state_nxt  = RUN;
                if (ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (long_eff) begin
                    pc_load     = 1'b0;
                    ifid_load   = 1'b0;
                    idex_load   = 1'b0;
                    exmem_flush = 1'b1;
                    ex_busy     = 1'b1;
                    state_nxt   = LONG;
                    cnt_nxt     = CNT_W'(LONG_LAT - 2);
                end else if (lu) begin
                    pc_load    = 1'b0;
                    ifid_load  = 1'b0;
                    idex_flush = 1'b1;
                end else if (id_halt) begin
                    state_nxt = HALT;
                end

                // Data access steals the memory port from fetch
                if (ex_branch_taken) begin
                    mem_sel = mem_access;
                end else if (mem_access) begin
                    mem_sel = 1'b1;
                    if (ifid_load && !ifid_flush) begin
                        pc_load    = 1'b0;
                        ifid_flush = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl with LONG_LAT = 8.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs2, id_halt, ex_mem_read, ex_branch_taken, ex_long_op, mem_access;
    logic       pc_load, ifid_load, idex_load, exmem_load, memwb_load;
    logic       ifid_flush, idex_flush, exmem_flush, mem_sel, ex_busy, halted;
    logic [10:0] obs;

    int checks   = 0;
    int failures = 0;

    // {pc,ifid,idex,exmem,memwb loads, ifid,idex,exmem flushes, mem_sel, ex_busy, halted}
    localparam logic [10:0] O_ZERO  = 11'b00000_000_000;
    localparam logic [10:0] O_RUN   = 11'b11111_000_000;
    localparam logic [10:0] O_LU    = 11'b00111_010_000;
    localparam logic [10:0] O_BR    = 11'b11111_110_000;
    localparam logic [10:0] O_BRMEM = 11'b11111_110_100;
    localparam logic [10:0] O_FRZ   = 11'b00011_001_010;
    localparam logic [10:0] O_FRZM  = 11'b00011_001_110;
    localparam logic [10:0] O_STR   = 11'b01111_100_100;
    localparam logic [10:0] O_LUSTR = 11'b00111_010_100;
    localparam logic [10:0] O_HALT  = 11'b01111_100_001;

    pipeline_ctrl #(.LONG_LAT(8)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2), .id_halt(id_halt),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .ex_long_op(ex_long_op), .mem_access(mem_access),
        .pc_load(pc_load), .ifid_load(ifid_load), .idex_load(idex_load),
        .exmem_load(exmem_load), .memwb_load(memwb_load),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .mem_sel(mem_sel), .ex_busy(ex_busy), .halted(halted)
    );

    always #5 clk = ~clk;

    assign obs = {pc_load, ifid_load, idex_load, exmem_load, memwb_load,
                  ifid_flush, idex_flush, exmem_flush, mem_sel, ex_busy, halted};

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0; id_halt = 1'b0;
        ex_rd = 5'd0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        ex_long_op = 1'b0; mem_access = 1'b0;
    endtask

    task automatic rand_inputs();
        id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_uses_rs2 = 1'($urandom);
        id_halt = 1'($urandom); ex_rd = 5'($urandom); ex_mem_read = 1'($urandom);
        ex_branch_taken = 1'($urandom); ex_long_op = 1'($urandom);
        mem_access = 1'($urandom);
    endtask

    // Inputs are applied 1 time unit after the edge; outputs sampled 2 units later
    task automatic check(input string tag, input logic [10:0] exp);
        #2;
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();

        // Reset with random inputs: every output low
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            rand_inputs();
            check("reset_zero", O_ZERO);
        end
        next_cycle();
        idle_inputs();
        rst = 1'b1;
        check("after_reset", O_RUN);

        // Load-use on rs1: one stall cycle
        next_cycle();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
        check("lu_rs1", O_LU);
        next_cycle();
        idle_inputs(); id_rs1 = 5'd5;
        check("lu_cleared", O_RUN);

        // rd = x0 never stalls
        next_cycle();
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
        check("lu_x0", O_RUN);

        // rs2 match only counts when rs2 is read
        next_cycle();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd3; id_rs2 = 5'd5; id_uses_rs2 = 1'b0;
        check("lu_rs2_unused", O_RUN);
        next_cycle();
        id_uses_rs2 = 1'b1;
        check("lu_rs2_used", O_LU);

        // Branch beats load-use, with and without a data access
        next_cycle();
        ex_branch_taken = 1'b1;
        check("branch_over_lu", O_BR);
        next_cycle();
        mem_access = 1'b1;
        check("branch_mem", O_BRMEM);

        // Long op: freeze t..t+6, release at t+7
        next_cycle();
        idle_inputs(); ex_long_op = 1'b1;
        check("long_start", O_FRZ);
        for (int i = 1; i <= 6; i++) begin
            next_cycle();
            idle_inputs();
            ex_long_op = 1'b1;
            ex_branch_taken = (i == 3);
            mem_access = (i == 5);
            check("long_freeze", (i == 5) ? O_FRZM : O_FRZ);
        end
        // Release cycle: long op masked, load-use applies
        next_cycle();
        idle_inputs(); ex_long_op = 1'b1;
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7;
        check("long_release_lu", O_LU);
        next_cycle();
        idle_inputs();
        check("long_after", O_RUN);

        // Reset in the middle of a long op aborts it
        next_cycle();
        ex_long_op = 1'b1;
        check("long2_start", O_FRZ);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            ex_long_op = 1'b0;
            check("long2_freeze", O_FRZ);
        end
        next_cycle();
        rst = 1'b0;
        check("long2_reset", O_ZERO);
        next_cycle();
        rst = 1'b1;
        check("long2_after_reset", O_RUN);

        // Structural hazard on the memory port
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            idle_inputs(); mem_access = 1'b1;
            check("struct_mem", O_STR);
        end
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            mem_access = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9;
            check("struct_lu", O_LUSTR);
        end

        // Halt: instruction advances, then halted state persists
        next_cycle();
        idle_inputs(); id_halt = 1'b1;
        check("halt_enter", O_RUN);
        next_cycle();
        idle_inputs();
        check("halted", O_HALT);
        for (int i = 0; i < 50; i++) begin
            next_cycle();
            rand_inputs();
            check("halt_hold", O_HALT | {8'd0, mem_access, 2'b00});
        end
        next_cycle();
        rst = 1'b0;
        check("halt_reset", O_ZERO);
        next_cycle();
        idle_inputs();
        rst = 1'b1;
        check("halt_exit", O_RUN);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and stall sequencer for the 5-stage pipelined RISC-V core. It drives the load and flush controls of the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB), which are N-bit load-enabled registers. It also arbitrates the single-ported unified memory between instruction fetch and data access. It handles load-use stalls, taken-branch flushes, multi-cycle EX operations (mul/div) and program halt.

## Interface
- LONG_LAT, default 8: total EX-stage occupancy in cycles of a long op; legal range 2–255.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- id_uses_rs2  in  1  ID instruction reads rs2
- id_halt  in  1  ID instruction is ecall/ebreak/fence (halt)
- ex_rd  in  5  rd of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- ex_long_op  in  1  EX instruction is a multi-cycle mul/div
- mem_access  in  1  MEM instruction reads or writes data memory
- pc_load, ifid_load, idex_load, exmem_load, memwb_load  out  1 each  register load enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (NOP/zero controls) on the next edge
- mem_sel  out  1  0 = fetch owns memory, 1 = data owns memory
- ex_busy  out  1  long op is holding EX
- halted  out  1  core halted

## Operation
- States: RUN, LONG, HALT. Counter cnt is 8 bits wide.
- All outputs are combinational from the state, cnt and the inputs.
- Default in RUN: all loads = 1, all flushes = 0, mem_sel = 0.
- Load-use hazard (lu) = ex_mem_read & ex_rd≠0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).

RUN rules, in priority order:
1. ex_branch_taken: pc_load = 1, ifid_flush = 1, idex_flush = 1. Overrides lu, id_halt and ex_long_op.
2. ex_long_op: pc_load, ifid_load and idex_load = 0; exmem_flush = 1; memwb_load = 1; ex_busy = 1. Next state is LONG with cnt = LONG_LAT−2.
3. lu: pc_load = 0, ifid_load = 0, idex_flush = 1.
4. id_halt, with no lu and no flush: the halt instruction advances normally. Next state is HALT.

Structural rule, applied on top of rules 2–4 and in HALT:
- mem_access forces mem_sel = 1.
- If the IF/ID register was otherwise loading a fetch, then pc_load = 0 and ifid_flush = 1.
- Under rule 1, mem_sel = mem_access; pc still loads the target.

LONG state:
- While cnt≠0: freeze exactly as in rule 2 and decrement cnt.
- When cnt==0 (release cycle): ex_busy = 0 and ex_long_op is masked. Evaluate as RUN rules 1, 3, 4 plus the structural rule. Next state is RUN (or HALT per rule 4).
- ex_branch_taken is ignored while cnt≠0.

HALT state:
- pc_load = 0 and ifid_flush = 1 every cycle.
- idex_load, exmem_load and memwb_load = 1, so the pipeline drains.
- halted = 1. Leaving HALT requires reset.

## Timing
Reset:
- rst low asynchronously forces state = RUN and cnt = 0.
- While rst is low, all loads, flushes, mem_sel, ex_busy and halted are 0.
- Reset mid-LONG or in HALT aborts immediately.
- The first RUN cycle after rst rises applies the RUN defaults.

Latency and stall length:
- Stalls and flushes take effect on the same-cycle edge; there is no pipeline latency in the controller itself.
- Long op asserted in RUN at cycle t: freeze during t … t+LONG_LAT−2, release at t+LONG_LAT−1. EX occupancy is exactly LONG_LAT cycles.
- LONG_LAT = 2 gives one freeze cycle, then release.
- A load-use stall lasts exactly 1 cycle: the next cycle the load is in MEM and lu is false.

Boundary conditions:
- lu together with mem_access: ifid holds (not flushed), pc holds, idex_flush = 1, mem_sel = 1.
- Branch together with mem_access: PC takes the target, both flushes apply, mem_sel = 1.
- halted rises in the cycle after the halt instruction leaves ID.

## Test plan
- Reset: hold rst = 0 for 3 cycles with random inputs → every output is 0. Release → pc_load = ifid_load = 1, mem_sel = 0, halted = 0.
- Load-use: ex_mem_read = 1, ex_rd = 5, id_rs1 = 5 → exactly 1 cycle of pc_load = 0, ifid_load = 0, idex_flush = 1. Repeat with ex_rd = 0 → no stall. Repeat with id_rs2 = 5 and id_uses_rs2 = 0 → no stall.
- Branch vs load-use: ex_branch_taken = 1 with lu true → pc_load = 1, ifid_flush = 1, idex_flush = 1.
- Long op, LONG_LAT = 8: ex_long_op pulse at cycle 10 → ex_busy high during cycles 10–16, pc/ifid/idex frozen, exmem_flush = 1. All loads = 1 at cycle 17. Assert rst low at cycle 13 → immediate idle, ex_busy = 0.
- Structural: mem_access = 1 for 2 cycles → mem_sel = 1, pc_load = 0, ifid_flush = 1 in both cycles. Same with lu true → ifid_flush = 0, ifid_load = 0.
- Halt: id_halt = 1 with no hazard → the next cycle shows halted = 1, pc_load = 0, memwb_load = 1. The state persists through 50 cycles of random inputs until rst.
